// File: rtl/tinymips_pkg.sv
// ============================================================================
// tinymips_pkg
// Shared encodings for the parametrised multicycle datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tinymips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B    = 2'd0;
    localparam logic [1:0] ALUSRCB_ONE  = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
    localparam logic [1:0] ALUSRCB_IMM4 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_HOLD   = 2'd3;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/regfile_p.sv
// ============================================================================
// regfile_p
// NREGS x WIDTH register file: two async read ports, one sync write port, r0 = 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_p #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // No write bypass: a same-cycle read sees the pre-write contents.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

`default_nettype wire

// File: rtl/datapath_mc_p.sv
// ============================================================================
// datapath_mc_p
// Multicycle MIPS-subset datapath with built-in multi-beat instruction fetch.
// Optional macro TINYMIPS_OVF_FLAG_EN adds the ovf output and write suppression.
// Revision: 1.0
// ============================================================================
`default_nettype none

module datapath_mc_p
    import tinymips_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int MEMW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       alucontrol,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic             iord,
    input  logic             memtoreg,
    input  logic             pcen,
    input  logic [1:0]       pcsource,
    input  logic             regdst,
    input  logic             regwrite,
    input  logic             fetch_start,
    input  logic [MEMW-1:0]  memdata,
    output logic [WIDTH-1:0] adr,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] writedata,
    output logic             zero,
`ifdef TINYMIPS_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             fetch_busy,
    output logic             fetch_done
);

    localparam int BEATS = 32 / MEMW;
    localparam int BYTES = MEMW / 8;
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [1:0]       state;
    logic [1:0]       beat;
    logic             last_beat;
    logic [WIDTH-1:0] pc, mdr, a, b, aluout;
    logic [WIDTH-1:0] rd1, rd2, wd;
    logic [WIDTH-1:0] srca, srcb, aluresult, nextpc;
    logic [WIDTH-1:0] imm, constx4, jump_target, mdr_in, beat_off;
    logic [AW-1:0]    wa;
    logic             we;

    assign fetch_busy = (state == FS_FETCH);
    assign fetch_done = (state == FS_DONE);
    assign last_beat  = (beat == 2'(BEATS - 1));
    assign beat_off   = WIDTH'(int'(beat) * BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FS_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                FS_IDLE: begin
                    beat <= '0;
                    if (fetch_start) state <= FS_FETCH;
                end
                FS_FETCH: begin
                    if (last_beat) begin
                        state <= FS_DONE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                FS_DONE:  state <= fetch_start ? FS_FETCH : FS_IDLE;
                default:  state <= FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
        end else if (fetch_busy) begin
            instr[int'(beat)*MEMW +: MEMW] <= memdata;
        end
    end

    // Fetch owns the PC; controller loads are only honoured outside FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (fetch_busy && last_beat) begin
            pc <= pc + WIDTH'(BEATS * BYTES);
        end else if (pcen && !fetch_busy) begin
            pc <= nextpc;
        end
    end

    generate
        if (MEMW < WIDTH) begin : g_mdr_zext
            assign mdr_in = {{(WIDTH-MEMW){1'b0}}, memdata};
        end else begin : g_mdr_trunc
            assign mdr_in = memdata[WIDTH-1:0];
        end
        if (WIDTH > 16) begin : g_imm_zext
            assign imm = {{(WIDTH-16){1'b0}}, instr[15:0]};
        end else begin : g_imm_trunc
            assign imm = instr[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (!fetch_busy) mdr <= mdr_in;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    assign constx4     = {imm[WIDTH-3:0], 2'b00};
    assign jump_target = {instr[WIDTH-3:0], 2'b00};
    assign wa          = regdst ? instr[11 +: AW] : instr[16 +: AW];
    assign wd          = memtoreg ? mdr : aluout;

    regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .ra1   (instr[21 +: AW]),
        .ra2   (instr[16 +: AW]),
        .wa    (wa),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_comb begin
        srca = alusrca ? a : pc;
        case (alusrcb)
            ALUSRCB_B:   srcb = b;
            ALUSRCB_ONE: srcb = WIDTH'(1);
            ALUSRCB_IMM: srcb = imm;
            default:     srcb = constx4;
        endcase
        case (alucontrol)
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: aluresult = '0;
        endcase
        case (pcsource)
            PCSRC_ALU:    nextpc = aluresult;
            PCSRC_ALUOUT: nextpc = aluout;
            PCSRC_JUMP:   nextpc = jump_target;
            default:      nextpc = pc;
        endcase
    end

    assign zero      = (aluresult == '0);
    assign writedata = b;
    assign adr       = fetch_busy ? (pc + beat_off) : (iord ? aluout : pc);

`ifdef TINYMIPS_OVF_FLAG_EN
    always_comb begin
        case (alucontrol)
            ALU_ADD: ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (aluresult[WIDTH-1] != srca[WIDTH-1]);
            ALU_SUB: ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (aluresult[WIDTH-1] != srca[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
    // ovf is only ever set for add/sub, so it alone gates the write.
    assign we = regwrite && !ovf;
`else
    assign we = regwrite;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_mc_p.sv
// ============================================================================
// tb_datapath_mc_p
// Randomised self-checking bench for datapath_mc_p with a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_datapath_mc_p;
    import tinymips_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int MEMW  = 8;

    logic             clk, reset;
    logic [2:0]       alucontrol;
    logic             alusrca, iord, memtoreg, pcen, regdst, regwrite, fetch_start;
    logic [1:0]       alusrcb, pcsource;
    logic [MEMW-1:0]  memdata;
    logic [WIDTH-1:0] adr, writedata;
    logic [31:0]      instr;
    logic             zero, fetch_busy, fetch_done;
`ifdef TINYMIPS_OVF_FLAG_EN
    logic             ovf;
`endif

    logic [7:0] mem [256];
    logic [7:0] m_pc;
    int errors = 0;
    int checks = 0;

    assign memdata = mem[adr];

    datapath_mc_p #(.WIDTH(WIDTH), .NREGS(NREGS), .MEMW(MEMW)) dut (
        .clk(clk), .reset(reset), .alucontrol(alucontrol), .alusrca(alusrca),
        .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg), .pcen(pcen),
        .pcsource(pcsource), .regdst(regdst), .regwrite(regwrite),
        .fetch_start(fetch_start), .memdata(memdata), .adr(adr), .instr(instr),
        .writedata(writedata), .zero(zero),
`ifdef TINYMIPS_OVF_FLAG_EN
        .ovf(ovf),
`endif
        .fetch_busy(fetch_busy), .fetch_done(fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int sx, sy;
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return 8'((int'(x) + int'(y)) % 256);
            3'b110:  return 8'((int'(x) - int'(y) + 256) % 256);
            3'b111:  return (sx < sy) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        for (int i = 0; i < 4; i++) mem[8'(int'(m_pc) + i)] = word[8*i +: 8];
        iord = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (adr !== 8'(int'(m_pc) + k) || fetch_busy !== 1'b1 || fetch_done !== 1'b0) begin
                errors++;
                $display("FAIL fetch_beat%0d: adr=%h busy=%b done=%b, expected adr=%h busy=1 done=0",
                         k, adr, fetch_busy, fetch_done, 8'(int'(m_pc) + k));
            end
            tick();
        end
        m_pc = 8'(int'(m_pc) + 4);
        checks++;
        if (instr !== word || fetch_done !== 1'b1 || fetch_busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: instr=%h done=%b busy=%b, expected instr=%h done=1 busy=0",
                     instr, fetch_done, fetch_busy, word);
        end
        tick();
        checks++;
        if (fetch_done !== 1'b0 || adr !== m_pc) begin
            errors++;
            $display("FAIL fetch_after: done=%b adr=%h, expected done=0 adr=%h", fetch_done, adr, m_pc);
        end
    endtask

    task automatic set_pc(input logic [7:0] v);
        do_fetch({24'h0, 2'b00, v[7:2]});
        pcsource = PCSRC_JUMP;
        pcen = 1'b1;
        tick();
        pcen = 1'b0;
        pcsource = PCSRC_HOLD;
        m_pc = {v[7:2], 2'b00};
        checks++;
        if (adr !== m_pc) begin
            errors++;
            $display("FAIL jump_pc: adr=%h, expected %h", adr, m_pc);
        end
    endtask

    task automatic write_reg(input logic use_rd, input logic [7:0] v);
        mem[m_pc] = v;
        alucontrol = ALU_AND;
        iord = 1'b0;
        tick();
        memtoreg = 1'b1;
        regdst = use_rd;
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
        memtoreg = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_pc = 8'h00;
        tick();
        checks++;
        if (adr !== 8'h00 || instr !== 32'h0 || fetch_busy !== 1'b0 || fetch_done !== 1'b0 ||
            writedata !== 8'h00 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: adr=%h instr=%h busy=%b done=%b wd=%h zero=%b, expected all 0, zero=1",
                     adr, instr, fetch_busy, fetch_done, writedata, zero);
        end
    endtask

    task automatic test_fetch;
        set_pc(8'h10);
        do_fetch(32'h78563412);
        set_pc(8'hFC);
        do_fetch($urandom);
        checks++;
        if (m_pc !== 8'h00 || adr !== 8'h00) begin
            errors++;
            $display("FAIL pc_wrap: adr=%h, expected 00", adr);
        end
    endtask

    task automatic test_reset_mid_fetch;
        for (int i = 0; i < 4; i++) mem[8'(int'(m_pc) + i)] = 8'(i + 8'hA1);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (instr !== 32'h0 || fetch_busy !== 1'b0 || adr !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_fetch: instr=%h busy=%b adr=%h, expected 0 0 00", instr, fetch_busy, adr);
        end
        tick();
        reset = 1'b0;
        m_pc = 8'h00;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (fetch_done !== 1'b0 || instr !== 32'h0) begin
                errors++;
                $display("FAIL reset_no_done: done=%b instr=%h, expected 0 0", fetch_done, instr);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [2];
        words[0] = $urandom;
        words[1] = $urandom;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++) mem[8'(int'(m_pc) + 4*f + i)] = words[f][8*i +: 8];
        alusrca = 1'b0;
        alusrcb = ALUSRCB_ONE;
        alucontrol = ALU_ADD;
        pcsource = PCSRC_ALU;
        fetch_start = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            pcen = 1'b1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (adr !== 8'(int'(m_pc) + k) || fetch_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_beat f%0d k%0d: adr=%h busy=%b, expected adr=%h busy=1",
                             f, k, adr, fetch_busy, 8'(int'(m_pc) + k));
                end
                if (k == 3) pcen = 1'b0;
                tick();
            end
            m_pc = 8'(int'(m_pc) + 4);
            checks++;
            if (fetch_done !== 1'b1 || instr !== words[f]) begin
                errors++;
                $display("FAIL b2b_done f%0d: done=%b instr=%h, expected 1 %h", f, fetch_done, instr, words[f]);
            end
            if (f == 1) fetch_start = 1'b0;
            tick();
        end
        pcsource = PCSRC_HOLD;
        checks++;
        if (fetch_busy !== 1'b0 || fetch_done !== 1'b0 || adr !== m_pc) begin
            errors++;
            $display("FAIL b2b_end: busy=%b done=%b adr=%h, expected 0 0 %h", fetch_busy, fetch_done, adr, m_pc);
        end
    endtask

    task automatic test_regfile;
        logic [7:0] old;
        old = 8'($urandom_range(1, 255));
        if (old == 8'h5A) old = 8'h3C;
        do_fetch(32'h00631800);
        write_reg(1'b1, old);
        tick();
        tick();
        checks++;
        if (writedata !== old) begin
            errors++;
            $display("FAIL r3_initial: got %h, expected %h", writedata, old);
        end
        mem[m_pc] = 8'h5A;
        tick();
        memtoreg = 1'b1;
        regdst = 1'b1;
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
        memtoreg = 1'b0;
        checks++;
        if (writedata !== old) begin
            errors++;
            $display("FAIL r3_no_bypass: got %h, expected %h", writedata, old);
        end
        tick();
        checks++;
        if (writedata !== 8'h5A) begin
            errors++;
            $display("FAIL r3_new: got %h, expected 5a", writedata);
        end
        do_fetch(32'h00000000);
        write_reg(1'b1, 8'hFF);
        tick();
        tick();
        checks++;
        if (writedata !== 8'h00) begin
            errors++;
            $display("FAIL r0_zero: got %h, expected 00", writedata);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] exp;
        exp = alu_ref(op, x, y);
        write_reg(1'b1, x);
        write_reg(1'b0, y);
        tick();
        tick();
        alusrca = 1'b1;
        alusrcb = ALUSRCB_B;
        alucontrol = op;
        #1;
        checks++;
        if (zero !== (exp == 8'h00)) begin
            errors++;
            $display("FAIL alu_zero op=%b a=%h b=%h: zero=%b, expected %b", op, x, y, zero, exp == 8'h00);
        end
        tick();
        iord = 1'b1;
        #1;
        checks++;
        if (adr !== exp || writedata !== y) begin
            errors++;
            $display("FAIL alu_result op=%b a=%h b=%h: aluout=%h B=%h, expected %h %h",
                     op, x, y, adr, writedata, exp, y);
        end
        iord = 1'b0;
    endtask

    task automatic test_alu_random;
        logic [2:0] ops [8];
        logic [7:0] x, y;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        do_fetch(32'h00220800);
        for (int i = 0; i < 12; i++) begin
            x = 8'($urandom_range(0, 255));
            y = (i == 0) ? x : 8'($urandom_range(0, 255));
            run_op((i == 0) ? 3'b110 : ops[$urandom_range(0, 7)], x, y);
        end
    endtask

    task automatic test_ovf_slt;
        logic [7:0] exp_r1;
        run_op(ALU_ADD, 8'h7F, 8'h01);
        alucontrol = ALU_ADD;
        #1;
`ifdef TINYMIPS_OVF_FLAG_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b, expected 1", ovf);
        end
        exp_r1 = 8'h7F;
`else
        exp_r1 = 8'h80;
`endif
        memtoreg = 1'b0;
        regdst = 1'b1;
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
        alusrcb = ALUSRCB_IMM;
        tick();
        tick();
        iord = 1'b1;
        #1;
        checks++;
        if (adr !== exp_r1) begin
            errors++;
            $display("FAIL ovf_write: r1=%h, expected %h", adr, exp_r1);
        end
        iord = 1'b0;
        run_op(ALU_SLT, 8'h80, 8'h01);
    endtask

    task automatic test_beq;
        logic [7:0] target;
        do_fetch(32'h00220805);
        write_reg(1'b1, 8'h22);
        write_reg(1'b0, 8'h22);
        tick();
        tick();
        target = 8'(int'(m_pc) + 8'h14);
        alusrca = 1'b0;
        alusrcb = ALUSRCB_IMM4;
        alucontrol = ALU_ADD;
        tick();
        alusrca = 1'b1;
        alusrcb = ALUSRCB_B;
        alucontrol = ALU_SUB;
        #1;
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL beq_zero: got %b, expected 1", zero);
        end
        pcsource = PCSRC_ALUOUT;
        pcen = 1'b1;
        tick();
        pcen = 1'b0;
        pcsource = PCSRC_HOLD;
        m_pc = target;
        checks++;
        if (adr !== target) begin
            errors++;
            $display("FAIL beq_pc: got %h, expected %h", adr, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1'b1;
        alucontrol = ALU_AND;
        alusrca = 1'b0;
        alusrcb = ALUSRCB_B;
        iord = 1'b0;
        memtoreg = 1'b0;
        pcen = 1'b0;
        pcsource = PCSRC_HOLD;
        regdst = 1'b0;
        regwrite = 1'b0;
        fetch_start = 1'b0;
        test_reset();
        test_fetch();
        test_reset_mid_fetch();
        test_back_to_back();
        test_regfile();
        test_alu_random();
        test_ovf_slt();
        test_beq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
